pcm_buffer_writer: RTL and testbench
====================================

PCM_BUFFER_WRITER -- requirements
Module: pcm_buffer_writer

Interface
REQ-001 Parameter BUFFER_ADDR_BITS, default 9, SHALL set the address width of each buffer.
REQ-002 Parameter BUFFER_SIZE_BYTES, default 2**BUFFER_ADDR_BITS, SHALL set the number of bytes per buffer.
REQ-003 Port clk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 Port rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 Port src_data_i  in  8  SHALL carry the PCM byte stream from the WAV parser.
REQ-006 Port src_valid_i  in  1  SHALL indicate that src_data_i is valid.
REQ-007 Port src_last_i  in  1  SHALL mark the final byte of the stream and is qualified by src_valid_i.
REQ-008 Port src_ready_o  out  1  SHALL indicate that the writer accepts a byte; a transfer occurs when src_valid_i and src_ready_o are both high.
REQ-009 Port codec_buffer_empty_i  in  1  SHALL carry the codec's level request for a new buffer.
REQ-010 Port codec_buffer_empty_ack_o  out  1  SHALL be a one-cycle acknowledge of the request.
REQ-011 Port codec_buffer_filled_o  out  1  SHALL be a one-cycle pulse marking the write buffer complete.
REQ-012 Port codec_buffer_sel_i  in  1  SHALL select the buffer on the codec read port.
REQ-013 Port codec_buffer_addr_i  in  BUFFER_ADDR_BITS  SHALL give the codec read address.
REQ-014 Port codec_buffer_data_o  out  8  SHALL be the registered read data.
REQ-015 Port stream_done_o  out  1  SHALL be high once the stream has been fully delivered.
REQ-016 Port buffers_filled_o  out  16  SHALL count filled pulses and saturate at 16'hFFFF.

Function
REQ-017 Storage SHALL be 2 x BUFFER_SIZE_BYTES bytes, indexed as {sel, addr}.
REQ-018 The write port SHALL be internal; the read port SHALL serve the codec.
REQ-019 codec_buffer_data_o SHALL equal mem[{codec_buffer_sel_i, codec_buffer_addr_i}] one cycle after those inputs are presented.
REQ-020 On a same-cycle read and write to the same location, the read SHALL return the old data.
REQ-021 The FSM SHALL have exactly the states IDLE, ACK, FILL, PAD, NOTIFY and DONE.
REQ-022 In IDLE: src_ready_o=0; when codec_buffer_empty_i=1, next state ACK.
REQ-023 In ACK: codec_buffer_empty_ack_o=1 for exactly this cycle; wr_addr<=0; next state FILL.
REQ-024 In FILL: src_ready_o=1.
REQ-025 In FILL, each accepted byte SHALL be written to {wr_sel, wr_addr}, then wr_addr<=wr_addr+1.
REQ-026 In FILL, an accepted byte at wr_addr==BUFFER_SIZE_BYTES-1 SHALL cause next state NOTIFY, with the end-of-stream flag set if src_last_i=1.
REQ-027 In FILL, an accepted byte with src_last_i=1 at any lower address SHALL set the end-of-stream flag and take the REQ-046 transition.
REQ-028 In PAD: src_ready_o=0; 8'h00 SHALL be written at each wr_addr, one byte per cycle, through BUFFER_SIZE_BYTES-1; then next state NOTIFY.
REQ-029 In NOTIFY: codec_buffer_filled_o=1 for exactly one cycle.
REQ-030 In NOTIFY: wr_sel SHALL toggle and buffers_filled_o SHALL increment, saturating.
REQ-031 Leaving NOTIFY: next state SHALL be DONE if the end-of-stream flag is set, else IDLE.
REQ-032 In DONE: stream_done_o=1 and src_ready_o=0; the FSM SHALL hold in DONE until reset and SHALL ignore codec_buffer_empty_i.
REQ-033 wr_sel SHALL be the complement of the buffer the codec is currently reading.
REQ-034 The first buffer written after reset SHALL be buffer 1, matching the codec's first select toggle.
REQ-035 src_valid_i=0 during FILL SHALL stall writing with no timeout and no state change.
REQ-036 An assertion of codec_buffer_empty_i while in ACK, FILL, PAD or NOTIFY SHALL be ignored.
REQ-037 An empty request still high on return to IDLE SHALL be served again.
REQ-038 wr_addr arithmetic SHALL be BUFFER_ADDR_BITS wide, and wr_addr SHALL never wrap within FILL or PAD.
REQ-039 src_ready_o, codec_buffer_empty_ack_o and codec_buffer_filled_o SHALL be decoded directly from the state register, with no extra latency.

Reset
REQ-040 On rst_n=0 at a clock edge: state<=IDLE, wr_sel<=1, wr_addr<=0, end-of-stream flag<=0.
REQ-041 On rst_n=0 at a clock edge: buffers_filled_o<=0, stream_done_o<=0, src_ready_o<=0, codec_buffer_empty_ack_o<=0, codec_buffer_filled_o<=0.
REQ-042 Buffer memory contents SHALL NOT be cleared by reset.
REQ-043 codec_buffer_data_o SHALL be reset to 8'h00.
REQ-044 Reset during FILL or PAD SHALL abandon the partial buffer and SHALL NOT emit a filled pulse.

Configuration
REQ-045 Macro PCM_WRITER_ZERO_PAD_EN SHALL control handling of a stream that ends mid-buffer.
REQ-046 With PCM_WRITER_ZERO_PAD_EN defined, src_last_i accepted below the last address SHALL go FILL->PAD->NOTIFY->DONE, delivering a zero-padded final buffer.
REQ-047 Without PCM_WRITER_ZERO_PAD_EN, src_last_i accepted below the last address SHALL go FILL->DONE with no filled pulse; the partial buffer is discarded and PAD is unreachable.

Verification (BUFFER_ADDR_BITS=4, 16-byte buffers)
REQ-048 Reset, then empty_i=1 -> ack pulse 1 cycle later; 16 bytes 0x00..0x0F streamed -> filled pulse; codec reads sel=1, addr=5 -> data 0x05 one cycle later; buffers_filled_o=1.
REQ-049 Two consecutive requests with 32 bytes streamed -> second buffer written to sel=0; buffers_filled_o=2; sel=1 contents unchanged.
REQ-050 src_valid_i toggled 1/0 each cycle during FILL -> exactly 16 writes, filled pulse after the 16th accepted byte, no extra writes.
REQ-051 src_last_i on byte 6 with PCM_WRITER_ZERO_PAD_EN -> addresses 7..15 read 0x00, filled pulse, stream_done_o=1; without the macro -> no filled pulse, stream_done_o=1.
REQ-052 src_last_i on byte 15 -> filled pulse, then DONE; a later empty_i=1 -> no ack.
REQ-053 rst_n=0 asserted at byte 8 of FILL -> no filled pulse, all outputs at reset values, next request writes sel=1 from addr 0.

Source files
------------

// File: rtl/pcm_buffer_writer.sv
// ---------------------------------------------------------------------------
// pcm_buffer_writer
//
// Purpose:
//   Takes the PCM byte stream from the WAV parser and writes it into one half
//   of a ping-pong buffer while the codec reads from the other half. Each
//   buffer fill starts when the codec raises a buffer-empty request. The
//   request is acknowledged, the buffer is filled, and a filled pulse is
//   emitted when the buffer is complete. After the last byte of the stream
//   has been delivered, the writer parks in DONE until reset.
//
// Optional feature:
//   PCM_WRITER_ZERO_PAD_EN - when defined, a stream that ends part-way
//   through a buffer has the rest of that buffer filled with 8'h00, and the
//   buffer is then delivered. When undefined, that partial buffer is dropped
//   and the writer goes straight to DONE with no filled pulse.
//
// Parameters:
//   BUFFER_ADDR_BITS   address width of one buffer
//   BUFFER_SIZE_BYTES  bytes per buffer
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   src_data_i/valid/last      PCM byte stream, handshake with src_ready_o
//   src_ready_o                writer accepts a byte this cycle
//   codec_buffer_empty_i       codec level request for a fresh buffer
//   codec_buffer_empty_ack_o   one-cycle acknowledge of that request
//   codec_buffer_filled_o      one-cycle pulse when a buffer is complete
//   codec_buffer_sel_i/addr_i  codec read port select and address
//   codec_buffer_data_o        registered read data (one cycle latency)
//   stream_done_o              whole stream delivered
//   buffers_filled_o           saturating count of filled pulses
// ---------------------------------------------------------------------------
module pcm_buffer_writer #(
   parameter int BUFFER_ADDR_BITS  = 9,
   parameter int BUFFER_SIZE_BYTES = 2**BUFFER_ADDR_BITS
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  src_data_i,
   input  logic                        src_valid_i,
   input  logic                        src_last_i,
   output logic                        src_ready_o,
   input  logic                        codec_buffer_empty_i,
   output logic                        codec_buffer_empty_ack_o,
   output logic                        codec_buffer_filled_o,
   input  logic                        codec_buffer_sel_i,
   input  logic [BUFFER_ADDR_BITS-1:0] codec_buffer_addr_i,
   output logic [7:0]                  codec_buffer_data_o,
   output logic                        stream_done_o,
   output logic [15:0]                 buffers_filled_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACK    = 3'd1,
      FILL   = 3'd2,
      PAD    = 3'd3,
      NOTIFY = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [BUFFER_ADDR_BITS-1:0] LAST_ADDR =
      BUFFER_ADDR_BITS'(BUFFER_SIZE_BYTES - 1);
   localparam int MEM_DEPTH = 2 * BUFFER_SIZE_BYTES;

   state_t                      state_q, state_d;
   logic                        wr_sel_q, wr_sel_d;
   logic [BUFFER_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
   logic                        eos_q, eos_d;
   logic [15:0]                 filled_cnt_q, filled_cnt_d;
   logic [7:0]                  rd_data_q;

   logic                        mem_we;
   logic [BUFFER_ADDR_BITS:0]   mem_waddr;
   logic [7:0]                  mem_wdata;
   logic [7:0]                  mem [MEM_DEPTH];

   logic                        accept;
   logic                        at_last;

   assign accept  = src_valid_i && (state_q == FILL);
   assign at_last = (wr_addr_q == LAST_ADDR);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   // NOTE: all sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wr_sel_q     <= 1'b1;   // codec starts on buffer 0, so we write 1
         wr_addr_q    <= '0;
         eos_q        <= 1'b0;
         filled_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_sel_q     <= wr_sel_d;
         wr_addr_q    <= wr_addr_d;
         eos_q        <= eos_d;
         filled_cnt_q <= filled_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   // NOTE: every signal written in a combinational block gets a default at
   // the top so no path through the case leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (codec_buffer_empty_i) state_d = ACK;
         ACK:    state_d = FILL;
         FILL: begin
            if (accept) begin
               if (at_last) begin
                  state_d = NOTIFY;
               end else if (src_last_i) begin
`ifdef PCM_WRITER_ZERO_PAD_EN
                  state_d = PAD;
`else
                  state_d = DONE;
`endif
               end
            end
         end
         PAD:    if (at_last) state_d = NOTIFY;
         NOTIFY: state_d = eos_q ? DONE : IDLE;
         DONE:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath next values and memory write port
   // ------------------------------------------------------------------------
   always_comb begin
      wr_sel_d     = wr_sel_q;
      wr_addr_d    = wr_addr_q;
      eos_d        = eos_q;
      filled_cnt_d = filled_cnt_q;
      mem_we       = 1'b0;
      mem_waddr    = {wr_sel_q, wr_addr_q};
      mem_wdata    = src_data_i;
      unique case (state_q)
         ACK: wr_addr_d = '0;
         FILL: begin
            if (accept) begin
               mem_we = 1'b1;
               // Hold at the last address instead of wrapping to 0.
               if (!at_last)  wr_addr_d = wr_addr_q + 1'b1;
               if (src_last_i) eos_d = 1'b1;
            end
         end
         PAD: begin
            mem_we    = 1'b1;
            mem_wdata = 8'h00;
            if (!at_last) wr_addr_d = wr_addr_q + 1'b1;
         end
         NOTIFY: begin
            wr_sel_d     = ~wr_sel_q;
            filled_cnt_d = (filled_cnt_q == 16'hFFFF) ? filled_cnt_q
                                                      : filled_cnt_q + 16'd1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Buffer memory: one internal write port, one registered codec read port
   // ------------------------------------------------------------------------
   // NOTE: the storage array has no reset; clearing it would force a
   // flop-based implementation and the contents are always written before
   // the codec is told to read them.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Read samples the pre-edge array, so a same-cycle write to the same
   // location returns the old byte.
   always_ff @(posedge clk) begin
      if (!rst_n) rd_data_q <= 8'h00;
      else        rd_data_q <= mem[{codec_buffer_sel_i, codec_buffer_addr_i}];
   end

   // ------------------------------------------------------------------------
   // Outputs decoded straight from the state register
   // ------------------------------------------------------------------------
   always_comb begin
      src_ready_o              = 1'b0;
      codec_buffer_empty_ack_o = 1'b0;
      codec_buffer_filled_o    = 1'b0;
      stream_done_o            = 1'b0;
      unique case (state_q)
         ACK:    codec_buffer_empty_ack_o = 1'b1;
         FILL:   src_ready_o              = 1'b1;
         NOTIFY: codec_buffer_filled_o    = 1'b1;
         DONE:   stream_done_o            = 1'b1;
         default: ;
      endcase
   end

   assign codec_buffer_data_o = rd_data_q;
   assign buffers_filled_o    = filled_cnt_q;

endmodule

// File: tb/tb_pcm_buffer_writer.sv
// ---------------------------------------------------------------------------
// tb_pcm_buffer_writer
//
// Self-checking bench for pcm_buffer_writer with 16-byte buffers. Codec reads
// come from a table of {sel, addr, expected byte} records; expected bytes are
// queued when a read is issued and popped when the registered data appears.
// Multi-cycle corner cases (stall, re-served request, collision, reset in
// FILL, end of stream) are hand-written sequences. Honours
// PCM_WRITER_ZERO_PAD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_pcm_buffer_writer;

   localparam int AW = 4;
   localparam int SZ = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    src_data_i = '0;
   logic          src_valid_i = 1'b0;
   logic          src_last_i = 1'b0;
   logic          src_ready_o;
   logic          codec_buffer_empty_i = 1'b0;
   logic          codec_buffer_empty_ack_o;
   logic          codec_buffer_filled_o;
   logic          codec_buffer_sel_i = 1'b0;
   logic [AW-1:0] codec_buffer_addr_i = '0;
   logic [7:0]    codec_buffer_data_o;
   logic          stream_done_o;
   logic [15:0]   buffers_filled_o;

   pcm_buffer_writer #(
      .BUFFER_ADDR_BITS (AW),
      .BUFFER_SIZE_BYTES(SZ)
   ) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .src_data_i              (src_data_i),
      .src_valid_i             (src_valid_i),
      .src_last_i              (src_last_i),
      .src_ready_o             (src_ready_o),
      .codec_buffer_empty_i    (codec_buffer_empty_i),
      .codec_buffer_empty_ack_o(codec_buffer_empty_ack_o),
      .codec_buffer_filled_o   (codec_buffer_filled_o),
      .codec_buffer_sel_i      (codec_buffer_sel_i),
      .codec_buffer_addr_i     (codec_buffer_addr_i),
      .codec_buffer_data_o     (codec_buffer_data_o),
      .stream_done_o           (stream_done_o),
      .buffers_filled_o        (buffers_filled_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          sel;
      logic [AW-1:0] addr;
      logic [7:0]    exp;
   } rd_vec_t;

   rd_vec_t    vecs[48];
   logic [7:0] exp_q[$];
   int         total = 0;
   int         bad   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  src_ready_o, 0);
      check({tag, "_ack"},    codec_buffer_empty_ack_o, 0);
      check({tag, "_filled"}, codec_buffer_filled_o, 0);
      check({tag, "_done"},   stream_done_o, 0);
      check({tag, "_count"},  buffers_filled_o, 0);
      check({tag, "_rdata"},  codec_buffer_data_o, 0);
   endtask

   // Raise the empty request and wait (bounded) for the ack; returns the
   // number of clocks until the ack was seen. Leaves the DUT in FILL.
   task automatic request(input bit keep_high, output int cycles);
      int cyc = 0;
      codec_buffer_empty_i = 1'b1;
      while (!codec_buffer_empty_ack_o && cyc < 20) begin
         tick();
         cyc++;
      end
      check("ack_seen", codec_buffer_empty_ack_o, 1);
      if (!keep_high) codec_buffer_empty_i = 1'b0;
      tick();
      check("ack_width", codec_buffer_empty_ack_o, 0);
      check("fill_ready", src_ready_o, 1);
      cycles = cyc;
   endtask

   // Push n bytes start, start+1, ...; src_last_i on byte last_idx (-1 for
   // none). With toggle set, src_valid_i alternates 1/0 and garbage is put
   // on the data bus while invalid.
   task automatic stream(input logic [7:0] start, input int n,
                         input int last_idx, input bit toggle);
      int idx = 0;
      int cyc = 0;
      bit ph  = 1'b1;
      bit acc;
      while (idx < n && cyc < 400) begin
         src_valid_i = toggle ? ph : 1'b1;
         ph          = ~ph;
         src_data_i  = src_valid_i ? start + 8'(idx) : 8'hEE;
         src_last_i  = src_valid_i && (idx == last_idx);
         acc         = src_valid_i && src_ready_o;
         tick();
         cyc++;
         if (acc) idx++;
      end
      src_valid_i = 1'b0;
      src_last_i  = 1'b0;
      src_data_i  = 8'h00;
      if (idx < n) check("stream_accepted", idx, n);
   endtask

   // Count cycles with the filled pulse high over a window, starting with
   // the current sample.
   task automatic expect_filled(input int exp, input int win);
      int n = 0;
      for (int i = 0; i < win; i++) begin
         if (codec_buffer_filled_o) n++;
         tick();
      end
      check("filled_pulses", n, exp);
   endtask

   task automatic read_one(input logic sel, input logic [AW-1:0] addr,
                           input logic [7:0] exp, input string name);
      codec_buffer_sel_i  = sel;
      codec_buffer_addr_i = addr;
      exp_q.push_back(exp);
      tick();
      check(name, codec_buffer_data_o, exp_q.pop_front());
   endtask

   task automatic run_reads(input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         read_one(vecs[i].sel, vecs[i].addr, vecs[i].exp,
                  $sformatf("rd_vec%0d", i));
   endtask

   task automatic do_reset();
      src_valid_i          = 1'b0;
      src_last_i           = 1'b0;
      codec_buffer_empty_i = 1'b0;
      rst_n                = 1'b0;
      tick();
      tick();
      check_reset_outputs("rst");
      rst_n = 1'b1;
   endtask

   initial begin
      int cyc;
      int acks;

      // Read-back table: buffer 1 with 0x00.., buffer 0 with 0xA0..,
      // buffer 1 rewritten with 0x30.. by the stalled stream.
      for (int i = 0; i < 16; i++) begin
         vecs[i]      = '{1'b1, AW'(i), 8'(i)};
         vecs[16 + i] = '{1'b0, AW'(i), 8'hA0 + 8'(i)};
         vecs[32 + i] = '{1'b1, AW'(i), 8'h30 + 8'(i)};
      end

      // ---- reset values, first buffer goes to sel=1 ----
      do_reset();
      request(1'b0, cyc);
      check("ack_latency", cyc, 1);
      stream(8'h00, 16, -1, 1'b0);
      check("full_notify_ready", src_ready_o, 0);
      expect_filled(1, 3);
      check("count_1", buffers_filled_o, 1);
      run_reads(0, 15);

      // ---- second buffer goes to sel=0, sel=1 untouched ----
      request(1'b0, cyc);
      stream(8'hA0, 16, -1, 1'b0);
      expect_filled(1, 3);
      check("count_2", buffers_filled_o, 2);
      run_reads(0, 31);

      // ---- stalled stream, request held high through FILL ----
      request(1'b1, cyc);
      stream(8'h30, 16, -1, 1'b1);
      check("stall_notify", codec_buffer_filled_o, 1);
      tick();
      check("stall_pulse_width", codec_buffer_filled_o, 0);
      check("count_3", buffers_filled_o, 3);
      tick();
      check("request_reserved", codec_buffer_empty_ack_o, 1);
      codec_buffer_empty_i = 1'b0;
      tick();
      check("fill4_ready", src_ready_o, 1);
      run_reads(32, 47);

      // ---- fourth buffer (sel=0): same-cycle read/write returns old data
      src_valid_i         = 1'b1;
      src_data_i          = 8'h40;
      codec_buffer_sel_i  = 1'b0;
      codec_buffer_addr_i = '0;
      exp_q.push_back(8'hA0);
      tick();
      check("collision_old", codec_buffer_data_o, exp_q.pop_front());
      stream(8'h41, 15, -1, 1'b0);
      expect_filled(1, 3);
      check("count_4", buffers_filled_o, 4);
      read_one(1'b0, 4'd0,  8'h40, "collision_new");
      read_one(1'b0, 4'd15, 8'h4F, "buf4_last");

      // ---- reset in the middle of FILL ----
      request(1'b0, cyc);
      stream(8'h60, 8, -1, 1'b0);
      rst_n = 1'b0;
      expect_filled(0, 3);
      check_reset_outputs("midfill");
      rst_n = 1'b1;

      // ---- restart on sel=1 from addr 0, last on final byte ----
      request(1'b0, cyc);
      stream(8'h70, 16, 15, 1'b0);
      expect_filled(1, 4);
      check("eos_done", stream_done_o, 1);
      check("eos_ready", src_ready_o, 0);
      check("eos_count", buffers_filled_o, 1);
      codec_buffer_empty_i = 1'b1;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         if (codec_buffer_empty_ack_o) acks++;
         tick();
      end
      codec_buffer_empty_i = 1'b0;
      check("done_ignores_req", acks, 0);
      check("done_hold", stream_done_o, 1);
      for (int i = 0; i < 16; i++)
         read_one(1'b1, AW'(i), 8'h70 + 8'(i), $sformatf("restart_rd%0d", i));

      // ---- stream ends on byte 6 of a buffer ----
      do_reset();
      request(1'b0, cyc);
      stream(8'h80, 7, 6, 1'b0);
`ifdef PCM_WRITER_ZERO_PAD_EN
      expect_filled(1, 20);
      check("short_done", stream_done_o, 1);
      check("short_count", buffers_filled_o, 1);
      for (int i = 0; i < 16; i++)
         read_one(1'b1, AW'(i), (i < 7) ? 8'h80 + 8'(i) : 8'h00,
                  $sformatf("pad_rd%0d", i));
`else
      check("short_done_now", stream_done_o, 1);
      expect_filled(0, 20);
      check("short_done", stream_done_o, 1);
      check("short_count", buffers_filled_o, 0);
      for (int i = 0; i < 16; i++)
         read_one(1'b1, AW'(i), (i < 7) ? 8'h80 + 8'(i) : 8'h70 + 8'(i),
                  $sformatf("nopad_rd%0d", i));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

endmodule
